// File: rtl/multi_port_mem_bus_pkg.sv
// Shared definitions for the multi-port memory bus: cache op codes,
// FSM state encodings, BUSY counter width and an op-decode helper.
package multi_port_mem_bus_pkg;

  // Cache-side op codes; 2'b11 is reserved and decodes as idle.
  localparam logic [1:0] IO_IDLE  = 2'd0;
  localparam logic [1:0] IO_READ  = 2'd1;
  localparam logic [1:0] IO_WRITE = 2'd2;

  // Controller FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Enough bits for a LATENCY of up to 15.
  localparam int unsigned CNT_W = 4;

  // True when the op code asks for an access.
  function automatic logic is_active_op(input logic [1:0] op);
    return (op == IO_READ) || (op == IO_WRITE);
  endfunction

endpackage

// File: rtl/multi_port_mem_bus_if.sv
// Cache <-> memory bus interface.
//   master : cache side, drives per-port op/address/write data.
//   slave  : memory controller, drives shared read data, one-hot done
//            pulses and the write snoop broadcast.
interface multi_port_mem_bus_if #(
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned WORDWIDTH = 16
);
  localparam int unsigned PORTW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [2*NPORTS-1:0]         rwFromCache;
  logic [NPORTS*ADDRWIDTH-1:0] addrFromCache;
  logic [NPORTS*WORDWIDTH-1:0] dataFromCache;
  logic [WORDWIDTH-1:0]        dataToCache;
  logic [NPORTS-1:0]           rdEnToCache;
  logic [NPORTS-1:0]           wbDoneToCache;
  logic                        busWrValid;
  logic [ADDRWIDTH-1:0]        busWrAddr;
  logic [PORTW-1:0]            busWrPort;

  modport master (
    output rwFromCache, addrFromCache, dataFromCache,
    input  dataToCache, rdEnToCache, wbDoneToCache,
    input  busWrValid, busWrAddr, busWrPort
  );

  modport slave (
    input  rwFromCache, addrFromCache, dataFromCache,
    output dataToCache, rdEnToCache, wbDoneToCache,
    output busWrValid, busWrAddr, busWrPort
  );

endinterface

// File: rtl/multi_port_mem_bus_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i           : per-port request vector
//   last_grant_i    : most recently granted port
//   grant_idx_c_o   : winning port, searched from last_grant_i+1 upward
//   grant_valid_c_o : at least one request present
module rr_arbiter #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [PW-1:0]     last_grant_i,
  output logic [PW-1:0]     grant_idx_c_o,
  output logic              grant_valid_c_o
);

  logic [PW-1:0] idx;

  // First requester after last_grant_i wins; last_grant_i itself is checked last.
  always_comb begin
    grant_idx_c_o   = '0;
    grant_valid_c_o = 1'b0;
    idx             = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      idx = PW'((32'(last_grant_i) + i) % NPORTS);
      if (!grant_valid_c_o && req_i[idx]) begin
        grant_valid_c_o = 1'b1;
        grant_idx_c_o   = idx;
      end
    end
  end

endmodule

// File: rtl/multi_port_mem_bus.sv
// Multi-port memory controller: round-robin grants one cache port at a
// time, holds BUSY for LATENCY cycles, then reports completion for one
// RESP cycle (read data / write done + snoop broadcast).
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of multi_port_mem_bus_if
module multi_port_mem_bus
  import multi_port_mem_bus_pkg::*;
#(
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned ADDRWIDTH = 16,
  parameter int unsigned WORDWIDTH = 16,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2
) (
  input logic                  clk,
  input logic                  reset,
  multi_port_mem_bus_if.slave  bus
);

  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]        last_grant_q, last_grant_d;
  logic                 is_wr_q, is_wr_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [WORDWIDTH-1:0] wdata_q, wdata_d;
  logic [PW-1:0]        port_q, port_d;
  logic [NPORTS-1:0]    rd_en_q, rd_en_d;
  logic [NPORTS-1:0]    wb_done_q, wb_done_d;
  logic [WORDWIDTH-1:0] rdata_q, rdata_d;
  logic                 bus_wr_valid_q, bus_wr_valid_d;
  logic [ADDRWIDTH-1:0] bus_wr_addr_q, bus_wr_addr_d;
  logic [PW-1:0]        bus_wr_port_q, bus_wr_port_d;
  logic                 mem_we_c;

  logic [NPORTS-1:0]    req_c;
  logic [PW-1:0]        grant_idx_c;
  logic                 grant_valid_c;

  logic [WORDWIDTH-1:0] mem [DEPTH];

  // Reserved op code 2'b11 never raises a request.
  always_comb begin
    req_c = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      req_c[p] = is_active_op(bus.rwFromCache[2*p +: 2]);
    end
  end

  rr_arbiter #(.NPORTS(NPORTS), .PW(PW)) u_arb (
    .req_i           (req_c),
    .last_grant_i    (last_grant_q),
    .grant_idx_c_o   (grant_idx_c),
    .grant_valid_c_o (grant_valid_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    is_wr_d        = is_wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    port_d         = port_q;
    rd_en_d        = '0;
    wb_done_d      = '0;
    rdata_d        = rdata_q;
    bus_wr_valid_d = 1'b0;
    bus_wr_addr_d  = bus_wr_addr_q;
    bus_wr_port_d  = bus_wr_port_q;
    mem_we_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          state_d      = ST_BUSY;
          cnt_d        = '0;
          last_grant_d = grant_idx_c;
          port_d       = grant_idx_c;
          is_wr_d      = (bus.rwFromCache[32'(grant_idx_c)*2 +: 2] == IO_WRITE);
          addr_d       = bus.addrFromCache[32'(grant_idx_c)*ADDRWIDTH +: ADDRWIDTH];
          wdata_d      = bus.dataFromCache[32'(grant_idx_c)*WORDWIDTH +: WORDWIDTH];
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          if (is_wr_q) begin
            mem_we_c       = 1'b1;
            wb_done_d      = NPORTS'(1) << port_q;
            bus_wr_valid_d = 1'b1;
            bus_wr_addr_d  = addr_q;
            bus_wr_port_d  = port_q;
          end else begin
            rd_en_d = NPORTS'(1) << port_q;
            rdata_d = mem[addr_q[IW-1:0]];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      last_grant_q   <= PW'(NPORTS - 1);
      is_wr_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      port_q         <= '0;
      rd_en_q        <= '0;
      wb_done_q      <= '0;
      rdata_q        <= '0;
      bus_wr_valid_q <= 1'b0;
      bus_wr_addr_q  <= '0;
      bus_wr_port_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      is_wr_q        <= is_wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      port_q         <= port_d;
      rd_en_q        <= rd_en_d;
      wb_done_q      <= wb_done_d;
      rdata_q        <= rdata_d;
      bus_wr_valid_q <= bus_wr_valid_d;
      bus_wr_addr_q  <= bus_wr_addr_d;
      bus_wr_port_q  <= bus_wr_port_d;
    end
  end

  // Memory array is not reset; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[addr_q[IW-1:0]] <= wdata_q;
    end
  end

  assign bus.dataToCache   = rdata_q;
  assign bus.rdEnToCache   = rd_en_q;
  assign bus.wbDoneToCache = wb_done_q;
  assign bus.busWrValid    = bus_wr_valid_q;
  assign bus.busWrAddr     = bus_wr_addr_q;
  assign bus.busWrPort     = bus_wr_port_q;

endmodule

// File: tb/tb_multi_port_mem_bus.sv
module tb_multi_port_mem_bus;
  import multi_port_mem_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_port_mem_bus_if #(.NPORTS(2), .ADDRWIDTH(16), .WORDWIDTH(16)) bus2 ();
  multi_port_mem_bus_if #(.NPORTS(4), .ADDRWIDTH(16), .WORDWIDTH(16)) bus4 ();

  multi_port_mem_bus #(.NPORTS(2), .ADDRWIDTH(16), .WORDWIDTH(16), .DEPTH(256), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  multi_port_mem_bus #(.NPORTS(4), .ADDRWIDTH(16), .WORDWIDTH(16), .DEPTH(256), .LATENCY(2)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus2.rwFromCache = '0;
    bus4.rwFromCache = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One transaction on bus2; captures outputs at the negedge where a done pulse shows.
  task automatic op2(input int p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [1:0] rd, output logic [1:0] wb,
                     output logic [15:0] dout, output logic bv, output logic [15:0] ba,
                     output logic bp);
    @(negedge clk);
    bus2.rwFromCache[2*p +: 2]    = op;
    bus2.addrFromCache[16*p +: 16] = a;
    bus2.dataFromCache[16*p +: 16] = d;
    lat = -1; rd = '0; wb = '0; dout = '0; bv = 1'b0; ba = '0; bp = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus2.rdEnToCache != 2'b00 || bus2.wbDoneToCache != 2'b00) begin
        lat  = i;
        rd   = bus2.rdEnToCache;
        wb   = bus2.wbDoneToCache;
        dout = bus2.dataToCache;
        bv   = bus2.busWrValid;
        ba   = bus2.busWrAddr;
        bp   = bus2.busWrPort;
        break;
      end
    end
    bus2.rwFromCache[2*p +: 2] = IO_IDLE;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus2.rwFromCache = '0; bus2.addrFromCache = '0; bus2.dataFromCache = '0;
    bus4.rwFromCache = '0; bus4.addrFromCache = '0; bus4.dataFromCache = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus2.rdEnToCache !== 2'b00) begin errors++; $display("FAIL reset_rden got %b want 00", bus2.rdEnToCache); end
    checks++; if (bus2.wbDoneToCache !== 2'b00) begin errors++; $display("FAIL reset_wbdone got %b want 00", bus2.wbDoneToCache); end
    checks++; if (bus2.dataToCache !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus2.dataToCache); end
    checks++; if (bus2.busWrValid !== 1'b0) begin errors++; $display("FAIL reset_bwvalid got %b want 0", bus2.busWrValid); end
    checks++; if (bus2.busWrAddr !== 16'h0000) begin errors++; $display("FAIL reset_bwaddr got %h want 0000", bus2.busWrAddr); end
    checks++; if (bus2.busWrPort !== 1'b0) begin errors++; $display("FAIL reset_bwport got %b want 0", bus2.busWrPort); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [1:0] rd, wb; logic [15:0] dout, ba; logic bv, bp;
    op2(0, IO_WRITE, 16'h0000, 16'h0003, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (wb !== 2'b01) begin errors++; $display("FAIL wr_done got %b want 01", wb); end
    checks++; if (rd !== 2'b00) begin errors++; $display("FAIL wr_no_rden got %b want 00", rd); end
    checks++; if (bv !== 1'b1) begin errors++; $display("FAIL wr_bwvalid got %b want 1", bv); end
    checks++; if (ba !== 16'h0000) begin errors++; $display("FAIL wr_bwaddr got %h want 0000", ba); end
    checks++; if (bp !== 1'b0) begin errors++; $display("FAIL wr_bwport got %b want 0", bp); end
    @(negedge clk);
    checks++; if (bus2.wbDoneToCache !== 2'b00 || bus2.busWrValid !== 1'b0) begin
      errors++; $display("FAIL wr_pulse_width got done=%b bv=%b want 00/0", bus2.wbDoneToCache, bus2.busWrValid);
    end
    op2(1, IO_READ, 16'h0000, 16'h0000, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (rd !== 2'b10) begin errors++; $display("FAIL rd_en got %b want 10", rd); end
    checks++; if (dout !== 16'h0003) begin errors++; $display("FAIL rd_data got %h want 0003", dout); end
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL rd_no_bwvalid got %b want 0", bv); end
  endtask

  task automatic test_alias();
    int lat; logic [1:0] rd, wb; logic [15:0] dout, ba; logic bv, bp;
    op2(0, IO_WRITE, 16'h0105, 16'hBEEF, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (ba !== 16'h0105) begin errors++; $display("FAIL alias_bwaddr got %h want 0105", ba); end
    op2(1, IO_READ, 16'h0005, 16'h0000, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL alias_read got %h want BEEF", dout); end
    op2(1, IO_WRITE, 16'h0009, 16'h1234, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (bp !== 1'b1) begin errors++; $display("FAIL wr_port1 got %b want 1", bp); end
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL data_hold got %h want BEEF", dout); end
  endtask

  task automatic test_illegal_op();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    bus2.rwFromCache[1:0] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.rdEnToCache != 2'b00 || bus2.wbDoneToCache != 2'b00) seen = 1'b1;
    end
    bus2.rwFromCache[1:0] = IO_IDLE;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL op11_ignored got done=1 want none"); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rd;
    apply_reset();
    bus2.addrFromCache = {16'h0005, 16'h0000};
    bus2.rwFromCache   = {IO_READ, IO_READ};
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i % 4 == 3) exp_rd = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
      else            exp_rd = 2'b00;
      checks++; if (bus2.rdEnToCache !== exp_rd || bus2.wbDoneToCache !== 2'b00) begin
        errors++; $display("FAIL b2b_cycle%0d got rd=%b wb=%b want rd=%b wb=00", i, bus2.rdEnToCache, bus2.wbDoneToCache, exp_rd);
      end
    end
    bus2.rwFromCache = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; logic [1:0] rd, wb; logic [15:0] dout, ba; logic bv, bp;
    logic seen;
    op2(0, IO_WRITE, 16'h0007, 16'h1111, lat, rd, wb, dout, bv, ba, bp);
    @(negedge clk);
    bus2.rwFromCache[3:2]   = IO_WRITE;
    bus2.addrFromCache[31:16] = 16'h0007;
    bus2.dataFromCache[31:16] = 16'h2222;
    @(negedge clk);
    reset = 1'b1;
    bus2.rwFromCache = '0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus2.wbDoneToCache != 2'b00 || bus2.busWrValid != 1'b0 || bus2.rdEnToCache != 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_pulse got pulse want none"); end
    op2(0, IO_READ, 16'h0007, 16'h0000, lat, rd, wb, dout, bv, ba, bp);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_read_latency got %0d want 3", lat); end
    checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL abort_mem_kept got %h want 1111", dout); end
  endtask

  task automatic test_rr4();
    logic [3:0] first, second, solo;
    int t_first, t_second, n;
    apply_reset();
    @(negedge clk);
    bus4.rwFromCache[3:2] = IO_READ;
    solo = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus4.rdEnToCache != 4'b0000) begin solo = bus4.rdEnToCache; break; end
    end
    bus4.rwFromCache[3:2] = IO_IDLE;
    checks++; if (solo !== 4'b0010) begin errors++; $display("FAIL rr4_solo got %b want 0010", solo); end
    @(negedge clk);
    bus4.rwFromCache[3:2] = IO_READ;
    bus4.rwFromCache[7:6] = IO_READ;
    first = '0; second = '0; t_first = -1; t_second = -1; n = 0;
    for (int i = 1; i <= 30 && n < 2; i++) begin
      @(negedge clk);
      if (bus4.rdEnToCache != 4'b0000) begin
        if (n == 0) begin first = bus4.rdEnToCache; t_first = i; end
        else        begin second = bus4.rdEnToCache; t_second = i; end
        n++;
        for (int p = 0; p < 4; p++) if (bus4.rdEnToCache[p]) bus4.rwFromCache[2*p +: 2] = IO_IDLE;
      end
    end
    bus4.rwFromCache = '0;
    checks++; if (first !== 4'b1000) begin errors++; $display("FAIL rr4_first got %b want 1000", first); end
    checks++; if (second !== 4'b0010) begin errors++; $display("FAIL rr4_second got %b want 0010", second); end
    checks++; if (t_first !== 3 || t_second !== 7) begin
      errors++; $display("FAIL rr4_timing got %0d/%0d want 3/7", t_first, t_second);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus2.rwFromCache = '0; bus2.addrFromCache = '0; bus2.dataFromCache = '0;
    bus4.rwFromCache = '0; bus4.addrFromCache = '0; bus4.dataFromCache = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_illegal_op();
    test_back_to_back();
    test_reset_abort();
    test_rr4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_mem_bus.md
MULTI_PORT_MEM_BUS -- requirements
Module: multi_port_mem_bus

Interface
REQ-001 Parameter NPORTS, default 2: number of cache-side request ports (2..8).
REQ-002 Parameter ADDRWIDTH, default 16: address width.
REQ-003 Parameter WORDWIDTH, default 16: data word width.
REQ-004 Parameter DEPTH, default 256: memory words, power of two, DEPTH <= 2**ADDRWIDTH.
REQ-005 Parameter LATENCY, default 2: BUSY cycles per access (1..15).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 rwFromCache  in  NPORTS*2  per-port op code (IO_IDLE/IO_READ/IO_WRITE), port p at bits [2p+1:2p].
REQ-009 addrFromCache  in  NPORTS*ADDRWIDTH  per-port address.
REQ-010 dataFromCache  in  NPORTS*WORDWIDTH  per-port write data.
REQ-011 dataToCache  out  WORDWIDTH  read data, shared by all ports.
REQ-012 rdEnToCache  out  NPORTS  one-hot, one-cycle read-done pulse.
REQ-013 wbDoneToCache  out  NPORTS  one-hot, one-cycle write-done pulse.
REQ-014 busWrValid  out  1  one-cycle pulse on every write commit (snoop broadcast).
REQ-015 busWrAddr  out  ADDRWIDTH  address of committed write, valid with busWrValid.
REQ-016 busWrPort  out  $clog2(NPORTS)  port that performed the committed write.

Function
REQ-017 FSM states IDLE, BUSY, RESP; IDLE->BUSY on any port with rw != IO_IDLE; BUSY->RESP after LATENCY cycles; RESP->IDLE unconditionally.
REQ-018 In IDLE, grant by round-robin: search starts at port (last_grant+1) mod NPORTS; last_grant resets to NPORTS-1 so port 0 wins first.
REQ-019 On grant, op, address, write data and port index are latched; later changes on any request input are ignored until IDLE.
REQ-020 Memory index = latched address modulo DEPTH (low $clog2(DEPTH) bits); upper bits ignored, no error.
REQ-021 Read: memory word registered onto dataToCache at the BUSY->RESP edge; rdEnToCache[grant] high during RESP only.
REQ-022 Write: memory updated at the BUSY->RESP edge; wbDoneToCache[grant], busWrValid, busWrAddr, busWrPort valid during RESP only.
REQ-023 dataToCache holds its last read value until the next read completes.
REQ-024 Request-to-done latency: done pulse LATENCY+1 cycles after the grant edge; IDLE cycle between transactions is mandatory.
REQ-025 Requester protocol: port holds rw until its done pulse, returns to IO_IDLE on the following edge; a port still requesting in IDLE is re-arbitrated as a new request.
REQ-026 Op code 2'b11 is treated as IO_IDLE.
REQ-027 All done pulses one-hot or zero; never two ports in one cycle.

Reset
REQ-028 On reset: state=IDLE, last_grant=NPORTS-1, rdEnToCache=0, wbDoneToCache=0, dataToCache=0, busWrValid=0, busWrAddr=0, busWrPort=0, BUSY counter=0.
REQ-029 Reset during BUSY or RESP aborts: no memory write, no done pulse, no busWrValid on the following cycles.
REQ-030 Memory array contents are not cleared by reset (preloadable hierarchically by benches).

Structure
REQ-031 IO_IDLE=2'd0, IO_READ=2'd1, IO_WRITE=2'd2 and the FSM state encodings belong in the shared definitions file.
REQ-032 Round-robin arbiter is a sub-module rr_arbiter (NPORTS request vector, last_grant in, grant index and valid out, combinational).

Verification
REQ-033 NPORTS=2, LATENCY=2: port0 writes 16'h0003 to addr 0 -> wbDoneToCache=2'b01 three cycles after grant, busWrValid=1, busWrAddr=0, busWrPort=0.
REQ-034 Then port1 reads addr 0 -> rdEnToCache=2'b10 pulse with dataToCache=16'h0003.
REQ-035 Both ports request continuously from reset -> grants alternate 0,1,0,1; each port done every 2*(LATENCY+2) cycles.
REQ-036 NPORTS=4, ports 1 and 3 request while last_grant=1 -> port 3 granted first, then port 1.
REQ-037 DEPTH=256: write 16'hBEEF to addr 16'h0105, read addr 16'h0005 -> returns 16'hBEEF.
REQ-038 Reset asserted during BUSY of a write to addr 7 (old value 16'h1111) -> no done pulse, no busWrValid, addr 7 still 16'h1111.
